// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling from an internal
// bit-period counter, single-cycle rx_valid / frame_err pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d;
    logic                 ferr_d;
    logic                 rx_meta;
    logic                 rx_s;

    // Synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            shreg     <= shreg_d;
            rx_data   <= data_d;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        data_d  = rx_data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            // Re-check the line at mid start bit to reject glitches.
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            // Counting from mid start bit, each full period lands on the middle of the next bit.
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_d                = '0;
                    shreg_d              = shreg >> 1;
                    shreg_d[DATA_BITS-1] = rx_s;
                    idx_d                = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            // Leaving at mid stop bit lets a back-to-back start edge be caught.
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            // A held-low line (break) must not be decoded as a stream of start bits.
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
